pc_unit_ras: RTL and testbench

//   Clocked program counter for the multicycle datapath with an integrated return-address stack (RAS).

---
 rtl/pc_unit_ras_if.sv | 46 ++++
 rtl/pc_unit_ras.sv | 148 ++++++++++++++
 tb/tb_pc_unit_ras.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pc_unit_ras_if.sv
// ---------------------------------------------------------------------------
// pc_unit_ras_if
//   Command/status bundle between the control FSM (master) and the program
//   counter unit with its return-address stack (slave).
//
//   Handshake: there is no valid/ready pair. The master presents pc_op and
//   target every cycle, and en qualifies them. With en=1 the command is
//   consumed on that rising edge. With en=0 the command is ignored and the
//   unit holds all of its state. The slave never back-pressures.
//
//   Signals
//     en         master->slave  update enable (0 = stall)
//     pc_op      master->slave  3-bit opcode
//     target     master->slave  branch offset / absolute address
//     pc         slave->master  current PC (registered)
//     pc_seq     slave->master  pc + INC (combinational)
//     ras_empty  slave->master  stack holds no entries
//     ras_full   slave->master  stack holds RAS_DEPTH entries
//     ras_ovf    slave->master  sticky: CALL while full
//     ras_unf    slave->master  sticky: RET while empty
//     op_err     slave->master  sticky: reserved opcode accepted
// ---------------------------------------------------------------------------
interface pc_unit_ras_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [2:0]       pc_op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_seq;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;
  logic             op_err;

  modport master (
    output en, pc_op, target,
    input  pc, pc_seq, ras_empty, ras_full, ras_ovf, ras_unf, op_err
  );

  modport slave (
    input  en, pc_op, target,
    output pc, pc_seq, ras_empty, ras_full, ras_ovf, ras_unf, op_err
  );
endinterface

// File: rtl/pc_unit_ras.sv
// ---------------------------------------------------------------------------
// pc_unit_ras
//   Program counter for the multicycle datapath, with an integrated
//   return-address stack (RAS). It selects the next PC from these sources:
//   hold, sequential increment, PC-relative branch, absolute jump,
//   call (push the return address, then jump) and return (pop).
//
//   Ports
//     clk   in  rising-edge clock
//     rst   in  synchronous, active-high reset; it dominates en and pc_op
//     bus   pc_unit_ras_if.slave  command inputs and status outputs
//
//   Opcodes: 000 HOLD, 001 INC, 010 BRANCH, 011 JUMP, 100 CALL, 101 RET,
//            11x reserved (the PC holds and op_err is set).
//
//   The RAS is a circular buffer with a top pointer and an entry count.
//   A CALL while the stack is full overwrites the oldest entry. This keeps
//   the newest RAS_DEPTH return addresses. A RET while the stack is empty
//   falls through to pc + INC.
// ---------------------------------------------------------------------------
module pc_unit_ras #(
  parameter int                  WIDTH     = 32,
  parameter logic [WIDTH-1:0]    RESET_VEC = '0,
  parameter int                  INC       = 4,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_unit_ras_if.slave  bus
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_JUMP   = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  // Architectural state
  logic [WIDTH-1:0] r_pc;
  logic [PW-1:0]    r_top;     // index of the most recent entry
  logic [CW-1:0]    r_count;   // valid entries, 0..RAS_DEPTH
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic             r_ovf;
  logic             r_unf;
  logic             r_err;

  // Next-state decode
  logic [WIDTH-1:0] w_pc_seq;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [PW-1:0]    w_top_inc;
  logic [PW-1:0]    w_top_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_set_err;

  assign w_pc_seq  = r_pc + INC_W;
  assign w_top_inc = r_top + PW'(1);
  assign w_top_dec = r_top - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);

  always_comb begin
    w_pc_nxt  = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_set_err = 1'b0;
    case (bus.pc_op)
      OP_HOLD:   w_pc_nxt = r_pc;
      OP_INC:    w_pc_nxt = w_pc_seq;
      // The offset is two's complement, so a plain modular add also
      // covers backward branches.
      OP_BRANCH: w_pc_nxt = r_pc + bus.target;
      OP_JUMP:   w_pc_nxt = bus.target;
      OP_CALL: begin
        w_pc_nxt  = bus.target;
        w_push    = 1'b1;
        w_set_ovf = w_full;
      end
      OP_RET: begin
        if (w_empty) begin
          w_pc_nxt  = w_pc_seq;
          w_set_unf = 1'b1;
        end else begin
          w_pc_nxt = r_stack[r_top];
          w_pop    = 1'b1;
        end
      end
      default: begin
        w_pc_nxt  = r_pc;
        w_set_err = 1'b1;
      end
    endcase
  end

  // PC, pointer, count and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VEC;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.en) begin
      r_pc <= w_pc_nxt;
      if (w_push) begin
        // A push when full advances top onto the oldest slot, so the
        // oldest entry is overwritten and the count saturates.
        r_top <= w_top_inc;
        if (!w_full) r_count <= r_count + CW'(1);
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - CW'(1);
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // Stack storage. The contents are not reset; the count alone marks
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && bus.en && w_push) r_stack[w_top_inc] <= w_pc_seq;
  end

  assign bus.pc        = r_pc;
  assign bus.pc_seq    = w_pc_seq;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = w_full;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;
  assign bus.op_err    = r_err;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;

  localparam int          W     = 32;
  localparam logic [31:0] RVEC  = 32'h100;
  localparam logic [31:0] INCV  = 32'd4;
  localparam int          DEPTH = 4;
  localparam int          EW    = 2*W + 5;

  logic clk;
  logic rst;

  pc_unit_ras_if #(.WIDTH(W)) bus ();

  pc_unit_ras #(
    .WIDTH(W), .RESET_VEC(RVEC), .INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The return-address stack is modelled as an unbounded list that is
  // trimmed from the oldest end.
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_ovf, m_unf, m_err;

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [EW-1:0] pack_exp();
    logic e, f;
    e = (m_ras.size() == 0);
    f = (m_ras.size() == DEPTH);
    return {m_pc, m_pc + INCV, e, f, m_ovf, m_unf, m_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc",        64'(bus.pc),        64'(e[EW-1 -: 32]));
      chk("pc_seq",    64'(bus.pc_seq),    64'(e[EW-33 -: 32]));
      chk("ras_empty", 64'(bus.ras_empty), 64'(e[4]));
      chk("ras_full",  64'(bus.ras_full),  64'(e[3]));
      chk("ras_ovf",   64'(bus.ras_ovf),   64'(e[2]));
      chk("ras_unf",   64'(bus.ras_unf),   64'(e[1]));
      chk("op_err",    64'(bus.op_err),    64'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Drive right after an edge. On the next edge, apply the same op to the
  // model and queue the expected state for the monitor.
  task automatic step(input logic e, input logic [2:0] op, input logic [31:0] t);
    bus.en = e; bus.pc_op = op; bus.target = t;
    @(posedge clk);
    if (e) begin
      case (op)
        3'b000: ;
        3'b001: m_pc = m_pc + INCV;
        3'b010: m_pc = m_pc + t;
        3'b011: m_pc = t;
        3'b100: begin
          if (m_ras.size() == DEPTH) m_ovf = 1'b1;
          m_ras.push_back(m_pc + INCV);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
          m_pc = t;
        end
        3'b101: begin
          if (m_ras.size() == 0) begin
            m_pc  = m_pc + INCV;
            m_unf = 1'b1;
          end else m_pc = m_ras.pop_back();
        end
        default: m_err = 1'b1;
      endcase
    end
    exp_q.push_back(pack_exp());
    #1;
  endtask

  task automatic do_reset(input logic e, input logic [2:0] op, input logic [31:0] t);
    rst = 1'b1; bus.en = e; bus.pc_op = op; bus.target = t;
    @(posedge clk);
    m_pc = RVEC; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    exp_q.push_back(pack_exp());
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] t;
    rst = 1'b0; bus.en = 1'b0; bus.pc_op = 3'b000; bus.target = '0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    @(posedge clk); #1;

    // Reset state
    do_reset(1'b0, 3'b000, 32'h0);

    // Sequencing with a stall
    step(1'b1, 3'b011, 32'h0);
    step(1'b1, 3'b001, 32'h0);
    step(1'b0, 3'b001, 32'h0);
    step(1'b1, 3'b001, 32'h0);

    // Branch (negative offset), jump, wrap-around increment
    step(1'b1, 3'b011, 32'h40);
    step(1'b1, 3'b010, 32'hFFFF_FFF0);
    step(1'b1, 3'b011, 32'h2000);
    step(1'b1, 3'b011, 32'hFFFF_FFFC);
    step(1'b1, 3'b001, 32'h0);

    // Nested call/return
    step(1'b1, 3'b011, 32'h10);
    step(1'b1, 3'b100, 32'h100);
    step(1'b1, 3'b100, 32'h200);
    step(1'b1, 3'b101, 32'h0);
    step(1'b1, 3'b101, 32'h0);

    // Overflow then underflow, with a stalled CALL in the middle
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 3'b100, 32'h1000 * i);
      if (i == 3) step(1'b0, 3'b100, 32'hDEAD_0000);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 3'b101, 32'h0);

    // Reset during an active CALL, then a reserved opcode
    step(1'b1, 3'b100, 32'h3000);
    do_reset(1'b1, 3'b100, 32'h4000);
    step(1'b1, 3'b110, 32'h0);
    step(1'b1, 3'b111, 32'h0);

    // Random mix with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
      end else begin
        // Mostly legal ops; reserved ones are rare so op_err stays informative
        op = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        case ($urandom_range(0, 3))
          0: t = $urandom;
          1: t = 32'($signed($urandom_range(0, 255)) - 128) & 32'hFFFF_FFFC;
          2: t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
          default: t = 32'($urandom_range(0, 1023)) << 2;
        endcase
        step(1'($urandom_range(0, 4) != 0), op, t);
      end
    end

    bus.en = 1'b0;
    // Let the monitor drain the queue, within a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
